fir_coeff_loader: RTL and testbench

Upstream control stage for the reconfigurable transposed FIR filter. It accepts coefficients from a host over a valid/ready stream and aligns the load to a sample boundary. It drives the filter's coefficient-RAM write interface: update flag, chip select, write enable, address, data and coefficient index. Slots beyond the requested tap count are zero-padded, so stale taps never survive a reload.

---
 rtl/fir_coeff_loader.sv | 170 +++++++++++++++++
 tb/tb_fir_coeff_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// Coefficient loader for the transposed FIR: takes host coefficients over valid/ready,
// starts on a sample strobe, and writes every RAM slot, padding unused taps with zero.
module fir_coeff_loader #(
  parameter int P_NUM_SLOT   = 40,
  parameter int P_BANK_DEPTH = 10
) (
  input  logic        iClk_12M,
  input  logic        iRsn,
  input  logic        iEnSample_300k,
  input  logic        iLoadReq,
  input  logic [5:0]  iNumTaps,
  input  logic        iCoeffValid,
  input  logic [15:0] iCoeffData,
  output logic        oCoeffReady,
  output logic        oBusy,
  output logic        oLoadDone,
  output logic        oCoeffiUpdateFlag,
  output logic        oCsnRam,
  output logic        oWrnRam,
  output logic [3:0]  oAddrRam,
  output logic [15:0] oWrDtRam,
  output logic [5:0]  oNumOfCoeff
);

  localparam logic [5:0] NUM_SLOT  = 6'(P_NUM_SLOT);
  localparam logic [3:0] LAST_BANK = 4'(P_BANK_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SMP,
    LOAD,
    DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic [5:0]  num_reg, num_next;
  // Bank offset kept alongside cnt so the address needs no divider.
  logic [3:0]  bank_reg, bank_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        flag_reg, flag_next;
  logic        csn_reg, csn_next;
  logic        wrn_reg, wrn_next;
  logic [3:0]  addr_reg, addr_next;
  logic [15:0] data_reg, data_next;
  logic [5:0]  idx_reg, idx_next;

  logic        host_phase;
  logic        write_en;
  logic [15:0] write_data;

  assign host_phase  = (state_reg == LOAD) && (cnt_reg < num_reg);
  assign oCoeffReady = host_phase;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    num_next   = num_reg;
    bank_next  = bank_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
    flag_next  = flag_reg;
    csn_next   = csn_reg;
    wrn_next   = wrn_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    idx_next   = idx_reg;
    write_en   = 1'b0;
    write_data = 16'd0;

    case (state_reg)
      IDLE: begin
        if (iLoadReq) begin
          num_next   = (iNumTaps > NUM_SLOT) ? NUM_SLOT : iNumTaps;
          busy_next  = 1'b1;
          state_next = WAIT_SMP;
        end
      end

      WAIT_SMP: begin
        if (iEnSample_300k) begin
          flag_next  = 1'b1;
          csn_next   = 1'b0;
          wrn_next   = 1'b1;
          cnt_next   = 6'd0;
          bank_next  = 4'd0;
          state_next = LOAD;
        end
      end

      LOAD: begin
        wrn_next = 1'b1;
        if (host_phase) begin
          if (iCoeffValid) begin
            write_en   = 1'b1;
            write_data = iCoeffData;
          end
        end else if (cnt_reg < NUM_SLOT) begin
          write_en   = 1'b1;
          write_data = 16'd0;
        end else begin
          flag_next  = 1'b0;
          csn_next   = 1'b1;
          done_next  = 1'b1;
          state_next = DONE;
        end

        if (write_en) begin
          wrn_next  = 1'b0;
          data_next = write_data;
          idx_next  = cnt_reg;
          addr_next = bank_reg + 4'd1;
          cnt_next  = cnt_reg + 6'd1;
          bank_next = (bank_reg == LAST_BANK) ? 4'd0 : bank_reg + 4'd1;
        end
      end

      DONE: begin
        done_next  = 1'b0;
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      state_reg <= IDLE;
      cnt_reg   <= 6'd0;
      num_reg   <= 6'd0;
      bank_reg  <= 4'd0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      flag_reg  <= 1'b0;
      csn_reg   <= 1'b1;
      wrn_reg   <= 1'b1;
      addr_reg  <= 4'd0;
      data_reg  <= 16'd0;
      idx_reg   <= 6'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      num_reg   <= num_next;
      bank_reg  <= bank_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      flag_reg  <= flag_next;
      csn_reg   <= csn_next;
      wrn_reg   <= wrn_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      idx_reg   <= idx_next;
    end
  end

  assign oBusy             = busy_reg;
  assign oLoadDone         = done_reg;
  assign oCoeffiUpdateFlag = flag_reg;
  assign oCsnRam           = csn_reg;
  assign oWrnRam           = wrn_reg;
  assign oAddrRam          = addr_reg;
  assign oWrDtRam          = data_reg;
  assign oNumOfCoeff       = idx_reg;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: randomized host traffic checked every cycle against a
// behavioural model, plus literal expectations on the recorded write sequence.
module tb_fir_coeff_loader;

  logic        clk = 1'b0;
  logic        rsn, smp, req, valid;
  logic [5:0]  ntaps;
  logic [15:0] cdata;
  logic        ready, busy, done, flag, csn, wrn;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [5:0]  widx;

  always #5 clk = ~clk;

  fir_coeff_loader dut (
    .iClk_12M(clk), .iRsn(rsn), .iEnSample_300k(smp), .iLoadReq(req),
    .iNumTaps(ntaps), .iCoeffValid(valid), .iCoeffData(cdata),
    .oCoeffReady(ready), .oBusy(busy), .oLoadDone(done),
    .oCoeffiUpdateFlag(flag), .oCsnRam(csn), .oWrnRam(wrn),
    .oAddrRam(addr), .oWrDtRam(wdata), .oNumOfCoeff(widx)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Behavioural model: expected outputs after the most recent clock edge.
  bit          m_ok = 0;
  bit          m_pending, m_active, m_busy, m_done, m_flag, m_csn, m_wrn;
  int          m_written, m_n;
  logic [3:0]  m_addr;
  logic [15:0] m_data;
  logic [5:0]  m_idx;

  task automatic m_write(input logic [15:0] d);
    m_wrn  = 1'b0;
    m_data = d;
    m_idx  = 6'(m_written);
    m_addr = 4'((m_written % 10) + 1);
    m_written++;
  endtask

  task automatic m_step(input bit r, input bit s, input bit q, input logic [5:0] nt,
                        input bit v, input logic [15:0] d);
    bit rdy;
    rdy = m_active && (m_written < m_n);
    if (!r) begin
      m_pending = 0; m_active = 0; m_busy = 0; m_done = 0; m_flag = 0;
      m_csn = 1; m_wrn = 1; m_addr = 0; m_data = 0; m_idx = 0;
      m_written = 0; m_n = 0; m_ok = 1;
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (m_active) begin
      m_wrn = 1;
      if (m_written == 40) begin
        m_active = 0; m_flag = 0; m_csn = 1; m_done = 1;
      end else if (rdy) begin
        if (v) m_write(d);
      end else begin
        m_write(16'd0);
      end
    end else if (m_pending) begin
      if (s) begin
        m_pending = 0; m_active = 1; m_flag = 1; m_csn = 0; m_wrn = 1; m_written = 0;
      end
    end else if (q) begin
      m_n = (int'(nt) > 40) ? 40 : int'(nt);
      m_pending = 1;
      m_busy = 1;
    end
  endtask

  // Observation statistics for the literal per-load checks.
  int          ncyc = 0, nlog, nready, ndone, nbusy_fall, nflag_idle, t_entry, t_done;
  bit          prev_flag = 0, prev_busy = 0;
  logic [5:0]  log_idx  [0:127];
  logic [3:0]  log_addr [0:127];
  logic [15:0] log_data [0:127];

  always @(negedge clk) begin
    logic [31:0] exp_v, act_v;
    bit          exp_rdy;
    if (m_ok) begin
      exp_rdy = m_active && (m_written < m_n);
      exp_v = {m_busy, m_done, m_flag, m_csn, m_wrn, m_addr, m_data, m_idx, exp_rdy};
      act_v = {busy, done, flag, csn, wrn, addr, wdata, widx, ready};
      check("outputs", 64'(act_v), 64'(exp_v));
    end
    ncyc++;
    if (wrn === 1'b0 && nlog < 128) begin
      log_idx[nlog] = widx; log_addr[nlog] = addr; log_data[nlog] = wdata; nlog++;
    end
    if (ready === 1'b1) nready++;
    if (done === 1'b1) begin ndone++; t_done = ncyc; end
    if (flag === 1'b1 && !prev_flag) t_entry = ncyc;
    if (flag === 1'b1 && wrn === 1'b1) nflag_idle++;
    if (prev_busy && busy === 1'b0) nbusy_fall++;
    prev_flag = (flag === 1'b1);
    prev_busy = (busy === 1'b1);
    m_step(rsn, smp, req, ntaps, valid, cdata);
  end

  // Host driver: k counts accepted coefficients, data is presented in order.
  int          k = 0;
  int          vmode = 0;
  logic [15:0] hd [0:63];

  task automatic cyc();
    bit hs;
    hs = valid && ready;
    @(posedge clk);
    #1;
    if (hs) k++;
    cdata = hd[k];
    if (vmode == 1) valid = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_stats();
    nlog = 0; nready = 0; ndone = 0; nbusy_fall = 0; nflag_idle = 0;
    t_entry = -1; t_done = -1;
  endtask

  task automatic start_load(input int n, input int d, input bit coinc);
    clear_stats();
    k = 0;
    cdata = hd[0];
    ntaps = 6'(n);
    req = 1; smp = coinc;
    cyc();
    req = 0; smp = 0;
    for (int i = 0; i < d - 1; i++) begin
      check("flag_before_strobe", 64'(flag), 64'(0));
      cyc();
    end
    smp = 1;
    cyc();
    smp = 0;
    check("flag_on_strobe", 64'(flag), 64'(1));
  endtask

  task automatic wait_k(input int target);
    int i;
    for (i = 0; i < 300 && k < target; i++) cyc();
    check("wait_k_timeout", 64'(k >= target), 64'(1));
  endtask

  task automatic wait_done(input int n_req);
    int i;
    for (i = 0; i < 400 && ndone == 0; i++) cyc();
    check("done_timeout", 64'(ndone != 0), 64'(1));
    cyc(); cyc();
    $display("load n=%0d writes=%0d entry_to_done=%0d done_pulses=%0d busy_falls=%0d",
             n_req, nlog, t_done - t_entry, ndone, nbusy_fall);
  endtask

  task automatic check_log(input int n_eff);
    check("write_count", 64'(nlog), 64'(40));
    for (int i = 0; i < 40 && i < nlog; i++) begin
      check("log_idx", 64'(log_idx[i]), 64'(i));
      check("log_addr", 64'(log_addr[i]), 64'((i % 10) + 1));
      check("log_data", 64'(log_data[i]), 64'((i < n_eff) ? hd[i] : 16'd0));
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) hd[i] = 16'($urandom);
  endtask

  initial begin
    rsn = 0; smp = 0; req = 0; valid = 0; ntaps = 0;
    fill_random();
    cdata = hd[0];
    clear_stats();
    repeat (3) cyc();
    check("rst_csn", 64'(csn), 64'(1));
    check("rst_wrn", 64'(wrn), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(ready), 64'(0));
    check("rst_addr", 64'(addr), 64'(0));
    rsn = 1;
    repeat (2) cyc();

    // Symmetric Kaiser-style set, 33 taps, valid held high.
    fill_random();
    hd[0] = 16'h0003; hd[1] = 16'h0000; hd[2] = 16'hFFFA; hd[16] = 16'h01F4;
    for (int i = 0; i < 16; i++) hd[32 - i] = hd[i];
    vmode = 0; valid = 1;
    start_load(33, 3, 0);
    wait_done(33);
    check_log(33);
    check("kaiser_latency", 64'(t_done - t_entry), 64'(41));
    check("kaiser_d16", 64'(log_data[16]), 64'(16'h01F4));
    check("kaiser_d32", 64'(log_data[32]), 64'(16'h0003));
    check("kaiser_a32", 64'(log_addr[32]), 64'(3));
    check("kaiser_a39", 64'(log_addr[39]), 64'(10));
    check("kaiser_pad33", 64'(log_data[33]), 64'(0));
    check("kaiser_idle", 64'(nflag_idle), 64'(1));
    check("kaiser_busyfall", 64'(nbusy_fall), 64'(1));

    // Three-cycle host stall right after index 5.
    vmode = 2; valid = 1;
    start_load(33, 3, 0);
    wait_k(6);
    valid = 0;
    repeat (3) cyc();
    valid = 1;
    wait_done(33);
    check_log(33);
    check("stall_latency", 64'(t_done - t_entry), 64'(44));
    check("stall_idle", 64'(nflag_idle), 64'(4));

    // Strobe coincident with the request is ignored; the next one, 8 cycles later, starts it.
    vmode = 0; valid = 1;
    fill_random();
    start_load(33, 8, 1);
    wait_done(33);
    check_log(33);

    // Zero taps: pure zero fill, never ready.
    start_load(0, 2, 0);
    wait_done(0);
    check_log(0);
    check("zero_ready", 64'(nready), 64'(0));
    check("zero_latency", 64'(t_done - t_entry), 64'(41));

    // 45 taps clamp to 40 host writes.
    fill_random();
    start_load(45, 2, 0);
    wait_done(45);
    check_log(40);
    check("clamp_ready", 64'(nready), 64'(40));
    check("clamp_d39", 64'(log_data[39]), 64'(hd[39]));

    // Request during an active load is ignored.
    start_load(33, 2, 0);
    wait_k(12);
    ntaps = 6'd3; req = 1;
    cyc();
    req = 0;
    wait_done(33);
    check_log(33);
    check("ignore_done", 64'(ndone), 64'(1));
    check("ignore_busyfall", 64'(nbusy_fall), 64'(1));

    // Reset mid-load at index 20, then a fresh full load.
    start_load(33, 2, 0);
    wait_k(20);
    rsn = 0;
    cyc();
    check("midrst_flag", 64'(flag), 64'(0));
    check("midrst_csn", 64'(csn), 64'(1));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_idx", 64'(widx), 64'(0));
    rsn = 1;
    repeat (3) cyc();
    check("midrst_nodone", 64'(ndone), 64'(0));
    $display("load n=33 aborted by reset after %0d writes", nlog);
    start_load(33, 2, 0);
    wait_done(33);
    check_log(33);
    check("after_rst_idx0", 64'(log_idx[0]), 64'(0));

    // Randomized loads with random valid gaps and strobe delays.
    for (int t = 0; t < 5; t++) begin
      int n, nlim;
      n = int'($urandom_range(0, 50));
      nlim = (n > 40) ? 40 : n;
      fill_random();
      vmode = 1;
      start_load(n, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
      wait_done(n);
      check_log(nlim);
      check("rand_done", 64'(ndone), 64'(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
